median_filter: RTL and testbench
================================

# median_filter

Streaming 3x3 median filter that removes impulse ("salt-and-pepper") noise from an 8-bit greyscale frame. It sits directly upstream of the brightness stage: it consumes raw noisy pixels in raster order and emits filtered pixels, in raster order, for the brightness stage to load. Two internal line buffers let it filter on the fly without holding a full frame. Border pixels pass through unchanged.

## Interface
Parameters:
- Width, 1080, pixels per row (>= 3)
- Depth, 1080, rows per frame (>= 3)

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_pixel carries a valid pixel this cycle
- in_pixel  in  8  raw pixel, raster order, row 0 column 0 first
- out_valid  out  1  out_pixel is valid this cycle (one cycle per pixel)
- out_pixel  out  8  filtered pixel, raster order
- busy  out  1  high in LOAD and FLUSH
- frame_done  out  1  one-cycle pulse after the last output pixel of a frame

## Operation
- States:
  - IDLE: counters are zero. A sampled in_valid is accepted as pixel 0 and moves the block to LOAD.
  - LOAD: every sampled in_valid is one push. After push Width*Depth-1, go to FLUSH.
  - FLUSH: Width+1 internal pushes of value 0, one per cycle, no gaps; in_valid is ignored. Then go to DONE.
  - DONE: frame_done=1 for one cycle, then return to IDLE.
- Push datapath:
  - Each push shifts the 3x3 window registers one column.
  - The new right column is {line buffer 1 output, line buffer 0 output, pushed pixel}.
  - Line buffers are Width-deep, 8-bit shift/circular RAMs addressed by the input column counter. Their contents are not cleared by reset.
- Output indexing:
  - Push p (0-based) completes the window centred on output pixel k = p-(Width+1).
  - Pushes with p < Width+1 produce no output.
  - Output coordinates: row orow = k / Width, column ocol = k % Width, tracked by counters rather than division.
- Output value:
  - If orow is 0 or Depth-1, or ocol is 0 or Width-1, out_pixel is the window centre, unchanged.
  - Otherwise out_pixel is the median of the 9 window pixels, computed by a compare-exchange sorting network.
  - Values are unsigned 8-bit; there is no arithmetic overflow.
- Each frame produces exactly Width*Depth outputs, in order.

## Timing
- Reset values (asynchronous): state=IDLE, out_valid=0, out_pixel=0, busy=0, frame_done=0, all counters and window registers 0.
- Latency:
  - Window registers update at the edge that samples a push (edge t).
  - out_valid/out_pixel are registered and updated at edge t+1, valid for one cycle.
- First output: out_valid rises one cycle after the edge accepting input pixel Width+1.
- Input gaps (in_valid=0 in LOAD) produce matching output gaps; nothing is lost or duplicated.
- FLUSH produces Width+1 consecutive out_valid cycles.
  - The last one is output pixel Width*Depth-1.
  - frame_done is asserted on the cycle after that last out_valid.
- in_valid during FLUSH or DONE is dropped. The upstream stage must not start the next frame until busy=0 and frame_done has pulsed.
- A new frame's first pixel is accepted in the cycle immediately after DONE (IDLE, in_valid=1).
- Reset mid-frame: the partial frame is abandoned and no further out_valid is produced. The next frame after reset is filtered correctly, because its interior outputs use only pixels from that frame.

## Test plan
- Reset: assert rst mid-cycle with in_valid=1 -> out_valid=0, out_pixel=0, busy=0, frame_done=0 immediately and held until release.
- Flat frame (Width=Depth=4, all pixels 50, in_valid every cycle) -> 16 out_valid cycles, all 50. First out_valid one cycle after the edge accepting pixel 5. frame_done pulses once, one cycle after the 16th output.
- Impulse (Width=Depth=5, all 10, pixel (2,2)=255) -> output (2,2)=10, all 25 outputs=10.
- Border pass-through (Width=Depth=4):
  - Input: border pixels 200, interior (1,1)=1, (1,2)=2, (2,1)=3, (2,2)=4.
  - Required: all 12 border outputs 200.
  - Interior medians, from window values: (1,1)=200, (1,2)=200, (2,1)=200, (2,2)=200.
  - Repeat with border 0: interior medians all 0.
- Bubbles: the impulse frame with in_valid deasserted randomly ~40% of cycles -> identical 25-output sequence, in order, no extras.
- Reset mid-frame then reuse: reset after 7 pixels, then the flat-50 frame -> exactly 16 outputs of 50 and one frame_done. A second back-to-back frame, all 90, started right after DONE -> 16 outputs of 90.

Source files
------------

// File: rtl/median_filter.sv
// Streaming 3x3 median filter for 8-bit greyscale raster frames.
// Two line buffers feed a 3x3 window; frame borders pass through.
module median_filter #(
  parameter int Width = 1080,
  parameter int Depth = 1080
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_pixel,
  output logic       out_valid,
  output logic [7:0] out_pixel,
  output logic       busy,
  output logic       frame_done
);
  localparam int Total = Width * Depth;
  localparam int PW = $clog2(Total + Width + 2);
  localparam int CW = $clog2(Width);
  localparam int RW = $clog2(Depth);

  localparam int LoIdx [19] = '{
    1, 4, 7, 0, 3, 6, 1, 4, 7, 0,
    5, 4, 3, 1, 2, 4, 4, 6, 4
  };
  localparam int HiIdx [19] = '{
    2, 5, 8, 1, 4, 7, 2, 5, 8, 3,
    8, 7, 6, 4, 5, 7, 2, 4, 2
  };

  typedef enum logic [1:0] {
    IDLE, LOAD, FLUSH, DONE
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] ocol_q, ocol_d;
  logic [RW-1:0] orow_q, orow_d;
  logic [7:0]    win_q [9];
  logic [7:0]    win_d [9];
  logic          win_vld_q, win_vld_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_pixel_q, out_pixel_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    lb0_q [Width];
  logic [7:0]    lb1_q [Width];

  logic          push;
  logic [7:0]    push_px;
  logic [7:0]    med;
  logic          border;

  always_comb begin : ctrl
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    col_d        = col_q;
    push         = 1'b0;
    push_px      = in_pixel;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          push    = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          push = 1'b1;
          if (pcnt_q == PW'(Total - 1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        push_px = '0;
        // one drain cycle lets the last output leave before DONE
        if (pcnt_q == PW'(Total + Width + 1)) state_d = DONE;
        else push = 1'b1;
      end
      DONE: begin
        frame_done_d = 1'b1;
        pcnt_d       = '0;
        col_d        = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (push) begin
      pcnt_d = pcnt_q + 1'b1;
      col_d  = (col_q == CW'(Width - 1)) ? '0 : col_q + 1'b1;
    end
    busy_d    = (state_d == LOAD) || (state_d == FLUSH);
    win_vld_d = push && (pcnt_q >= PW'(Width + 1));
  end

  always_comb begin : window
    win_d = win_q;
    if (push) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r*3]   = win_q[r*3+1];
        win_d[r*3+1] = win_q[r*3+2];
      end
      win_d[2] = lb1_q[col_q];
      win_d[5] = lb0_q[col_q];
      win_d[8] = push_px;
    end
  end

  always_comb begin : sort_net
    logic [7:0] s [9];
    logic [7:0] a, b;
    logic [3:0] lo, hi;
    s = win_q;
    for (int i = 0; i < 19; i++) begin
      lo    = 4'(LoIdx[5'(i)]);
      hi    = 4'(HiIdx[5'(i)]);
      a     = s[lo];
      b     = s[hi];
      s[lo] = (a > b) ? b : a;
      s[hi] = (a > b) ? a : b;
    end
    med = s[4];
  end

  always_comb begin : outp
    out_valid_d = win_vld_q;
    out_pixel_d = out_pixel_q;
    ocol_d      = ocol_q;
    orow_d      = orow_q;
    border      = (orow_q == '0) || (orow_q == RW'(Depth - 1)) ||
                  (ocol_q == '0) || (ocol_q == CW'(Width - 1));
    if (win_vld_q) begin
      out_pixel_d = border ? win_q[4] : med;
      if (ocol_q == CW'(Width - 1)) begin
        ocol_d = '0;
        orow_d = (orow_q == RW'(Depth - 1)) ? '0 : orow_q + 1'b1;
      end else begin
        ocol_d = ocol_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pcnt_q       <= '0;
      col_q        <= '0;
      ocol_q       <= '0;
      orow_q       <= '0;
      win_vld_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_pixel_q  <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      col_q        <= col_d;
      ocol_q       <= ocol_d;
      orow_q       <= orow_d;
      win_vld_q    <= win_vld_d;
      out_valid_q  <= out_valid_d;
      out_pixel_q  <= out_pixel_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // line buffers keep stale data across reset; only frame pixels reach interior outputs
  always_ff @(posedge clk) begin
    if (push) begin
      lb0_q[col_q] <= push_px;
      lb1_q[col_q] <= lb0_q[col_q];
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_median_filter.sv
// Scoreboard bench for median_filter: 4x4 and 5x5 instances
// checked against a sort-based reference median model.
module tb_median_filter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       iv4, iv5, ov4, ov5, bz4, bz5, fd4, fd5;
  logic [7:0] ip4, ip5, op4, op5;

  median_filter #(.Width(4), .Depth(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_pixel(ip4),
    .out_valid(ov4), .out_pixel(op4), .busy(bz4), .frame_done(fd4)
  );
  median_filter #(.Width(5), .Depth(5)) u5 (
    .clk(clk), .rst(rst), .in_valid(iv5), .in_pixel(ip5),
    .out_valid(ov5), .out_pixel(op5), .busy(bz5), .frame_done(fd5)
  );

  logic [7:0] expq0 [$];
  logic [7:0] expq1 [$];
  int fd_cnt [2];
  int last_ov [2];
  int frames [2];
  int checks = 0;
  int errors = 0;
  logic lat_arm = 1'b0;
  int first_ov = -1;
  int acc5 = -1;

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", n, act, exp, $time);
    end
  endtask

  task automatic mon(int s, logic v, logic [7:0] px, logic f);
    int qs;
    if (v) begin
      qs = (s == 0) ? expq0.size() : expq1.size();
      checks++;
      if (qs == 0) begin
        errors++;
        $display("FAIL extra_out%0d: got pixel %0d expected none", s, px);
      end else begin
        logic [7:0] e;
        e = (s == 0) ? expq0.pop_front() : expq1.pop_front();
        if (px != e) begin
          errors++;
          $display("FAIL pix%0d: got %0d expected %0d (t=%0t)", s, px, e, $time);
        end
      end
      last_ov[s] = cyc;
      if (s == 0 && lat_arm && first_ov < 0) first_ov = cyc;
    end
    if (f) begin
      fd_cnt[s]++;
      chk($sformatf("fd_gap%0d", s), cyc - last_ov[s], 1);
      qs = (s == 0) ? expq0.size() : expq1.size();
      chk($sformatf("fd_drained%0d", s), qs, 0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, ov4, op4, fd4);
      mon(1, ov5, op5, fd5);
    end
  end

  task automatic push_exp(int s, logic [7:0] v);
    if (s == 0) expq0.push_back(v);
    else expq1.push_back(v);
  endtask

  // reference: border copies the pixel, interior takes the 5th smallest of 9
  task automatic expect_frame(int s, int w, int d, logic [7:0] img [$]);
    int q [$];
    for (int r = 0; r < d; r++) begin
      for (int c = 0; c < w; c++) begin
        if (r == 0 || r == d - 1 || c == 0 || c == w - 1) begin
          push_exp(s, img[r*w+c]);
        end else begin
          q.delete();
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              q.push_back(int'(img[(r+dr)*w+c+dc]));
          q.sort();
          push_exp(s, 8'(q[4]));
        end
      end
    end
  endtask

  task automatic drive(int s, logic v, logic [7:0] p);
    if (s == 0) begin iv4 = v; ip4 = p; end
    else begin iv5 = v; ip5 = p; end
  endtask

  task automatic send(int s, logic [7:0] img [$], int gap_pct, int n);
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        drive(s, 1'b0, 8'h00);
        @(posedge clk); #1;
      end
      drive(s, 1'b1, img[i]);
      @(posedge clk); #1;
      if (s == 0 && lat_arm && i == 5) acc5 = cyc;
    end
    drive(s, 1'b0, 8'h00);
  endtask

  task automatic wait_done(int s, int start);
    int n = 0;
    while (fd_cnt[s] == start && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    chk($sformatf("frame_done_seen%0d", s), fd_cnt[s] - start, 1);
  endtask

  task automatic run_frame(int s, int w, logic [7:0] img [$], int gap_pct);
    int start;
    start = fd_cnt[s];
    frames[s]++;
    expect_frame(s, w, w, img);
    send(s, img, gap_pct, w * w);
    wait_done(s, start);
  endtask

  task automatic mk_flat(output logic [7:0] img [$], input int n, input logic [7:0] v);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(v);
  endtask

  initial begin
    logic [7:0] img [$];
    fd_cnt = '{0, 0};
    last_ov = '{0, 0};
    frames = '{0, 0};
    rst = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ov4", ov4, 0); chk("rst_op4", op4, 0);
    chk("rst_bz4", bz4, 0); chk("rst_fd4", fd4, 0);
    chk("rst_ov5", ov5, 0); chk("rst_op5", op5, 0);
    chk("rst_bz5", bz5, 0); chk("rst_fd5", fd5, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // partial frame: 7 pixels, then reset mid-cycle with in_valid high
    mk_flat(img, 16, 8'd50);
    send(0, img, 0, 7);
    drive(0, 1'b1, 8'd50);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ov", ov4, 0); chk("midrst_op", op4, 0);
    chk("midrst_bz", bz4, 0); chk("midrst_fd", fd4, 0);
    repeat (2) begin
      @(negedge clk);
      chk("hold_ov", ov4, 0); chk("hold_bz", bz4, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b0, 8'h00);
    @(posedge clk); #1;

    lat_arm = 1'b1;
    run_frame(0, 4, img, 0);
    chk("first_out_latency", first_ov - acc5, 1);
    lat_arm = 1'b0;
    mk_flat(img, 16, 8'd90);
    run_frame(0, 4, img, 0);

    for (int b = 0; b < 2; b++) begin
      mk_flat(img, 16, (b == 0) ? 8'd200 : 8'd0);
      img[5] = 8'd1; img[6] = 8'd2; img[9] = 8'd3; img[10] = 8'd4;
      run_frame(0, 4, img, 0);
    end

    mk_flat(img, 25, 8'd10);
    img[12] = 8'd255;
    run_frame(1, 5, img, 0);
    run_frame(1, 5, img, 40);

    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 2; s++) begin
        img.delete();
        for (int i = 0; i < (s == 0 ? 16 : 25); i++)
          img.push_back(8'($urandom));
        run_frame(s, (s == 0) ? 4 : 5, img, int'($urandom_range(50)));
      end
    end

    repeat (10) @(posedge clk);
    #1;
    chk("leftover4", expq0.size(), 0);
    chk("leftover5", expq1.size(), 0);
    chk("fd_total4", fd_cnt[0], frames[0]);
    chk("fd_total5", fd_cnt[1], frames[1]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end
endmodule
